// File: rtl/pid_pkg.sv
// Shared types and width/saturation helpers for the time-multiplexed PID controller.
package pid_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ERR,
        P,
        I,
        D,
        OUT
    } state_t;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int ch_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // sp - pv of two unsigned BITS values
    function automatic int err_w(input int bits);
        return bits + 1;
    endfunction

    // difference of two errors
    function automatic int der_w(input int bits);
        return bits + 2;
    endfunction

    // three gain*operand products summed without overflow
    function automatic int acc_w(input int acc_bits, input int bits);
        return acc_bits + bits + 3;
    endfunction

    // widest multiplier operand: integrator or derivative
    function automatic int op_w(input int acc_bits, input int bits);
        return max_i(acc_bits, der_w(bits));
    endfunction

    function automatic longint sat_max(input int w, input bit is_signed);
        return is_signed ? (64'sd1 <<< (w - 1)) - 64'sd1 : (64'sd1 <<< w) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int w, input bit is_signed);
        return is_signed ? -(64'sd1 <<< (w - 1)) : 64'sd0;
    endfunction

endpackage

// File: rtl/pid_sat.sv
// Clamps a signed value into a signed or unsigned OUT_W range and flags which side clipped.
module pid_sat
    import pid_pkg::*;
#(
    parameter int IN_W       = 17,
    parameter int OUT_W      = 16,
    parameter bit OUT_SIGNED = 1'b1
) (
    input  logic signed [IN_W-1:0]  din,
    output logic        [OUT_W-1:0] dout,
    output logic                    sat_hi,
    output logic                    sat_lo
);

    localparam logic signed [IN_W-1:0] MAX_V = IN_W'(sat_max(OUT_W, OUT_SIGNED));
    localparam logic signed [IN_W-1:0] MIN_V = IN_W'(sat_min(OUT_W, OUT_SIGNED));

    // NOTE: every output gets a default first so this always_comb never infers a latch.
    always_comb begin
        sat_hi = (din > MAX_V);
        sat_lo = (din < MIN_V);
        dout   = din[OUT_W-1:0];
        if (sat_hi) begin
            dout = MAX_V[OUT_W-1:0];
        end else if (sat_lo) begin
            dout = MIN_V[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/pid_mux.sv
// CHANNELS independent PID loops sharing one signed multiplier, one sample at a time.
// Per-channel integrator and previous error live in register arrays indexed by channel.
module pid_mux
    import pid_pkg::*;
#(
    parameter int BITS     = 8,
    parameter int CHANNELS = 4,
    parameter int ACC_BITS = 16,
    parameter int OUT_BITS = 8,
    parameter int KSHIFT   = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          pv_stb,
    input  logic [ch_w(CHANNELS)-1:0]     pv_ch,
    input  logic                          int_clr,
    input  logic [BITS-1:0]               sp,
    input  logic [BITS-1:0]               pv,
    input  logic [BITS-1:0]               kp,
    input  logic [BITS-1:0]               ki,
    input  logic [BITS-1:0]               kd,
    output logic                          busy,
    output logic                          out_stb,
    output logic [ch_w(CHANNELS)-1:0]     out_ch,
    output logic [OUT_BITS-1:0]           stimulus
);

    localparam int CH_W   = ch_w(CHANNELS);
    localparam int E_W    = err_w(BITS);
    localparam int DER_W  = der_w(BITS);
    localparam int ACC_W  = acc_w(ACC_BITS, BITS);
    localparam int OP_W   = op_w(ACC_BITS, BITS);
    localparam int PROD_W = OP_W + BITS + 1;

    state_t state, next_state;

    logic [CH_W-1:0] ch_q;
    logic            clr_q;
    logic [BITS-1:0] sp_q, pv_q, kp_q, ki_q, kd_q;

    logic signed [ACC_BITS-1:0] integ    [CHANNELS];
    logic signed [E_W-1:0]      prev_err [CHANNELS];

    logic signed [E_W-1:0]      e_q;
    logic signed [DER_W-1:0]    d_q;
    logic signed [ACC_BITS-1:0] integ_new_q;
    logic signed [ACC_BITS-1:0] integ_old_q;
    logic signed [ACC_W-1:0]    acc;

    logic accept;
    assign accept = (state == IDLE) && pv_stb && ({1'b0, pv_ch} < (CH_W + 1)'(CHANNELS));

    // ---------------- FSM ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = ERR;
            ERR:     next_state = P;
            P:       next_state = I;
            I:       next_state = D;
            D:       next_state = OUT;
            OUT:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        out_stb = (state == OUT);
    end

    // ---------------- error stage ----------------
    logic signed [E_W-1:0]      e_cur;
    logic signed [E_W-1:0]      prev_prior;
    logic signed [ACC_BITS-1:0] integ_prior;
    logic signed [ACC_BITS:0]   integ_sum;
    logic signed [ACC_BITS-1:0] integ_clamped;
    logic signed [DER_W-1:0]    d_cur;
    logic [1:0]                 integ_sat_unused;

    always_comb begin
        e_cur       = $signed({1'b0, sp_q}) - $signed({1'b0, pv_q});
        integ_prior = clr_q ? '0 : integ[ch_q];
        prev_prior  = clr_q ? '0 : prev_err[ch_q];
        integ_sum   = (ACC_BITS + 1)'(integ_prior) + (ACC_BITS + 1)'(e_cur);
        d_cur       = DER_W'(e_cur) - DER_W'(prev_prior);
    end

    pid_sat #(
        .IN_W       (ACC_BITS + 1),
        .OUT_W      (ACC_BITS),
        .OUT_SIGNED (1'b1)
    ) u_integ_sat (
        .din    (integ_sum),
        .dout   (integ_clamped),
        .sat_hi (integ_sat_unused[1]),
        .sat_lo (integ_sat_unused[0])
    );

    // ---------------- shared multiplier ----------------
    logic        [BITS-1:0]   gain;
    logic signed [OP_W-1:0]   mul_op;
    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  acc_sum;

    always_comb begin
        gain   = '0;
        mul_op = '0;
        case (state)
            P: begin gain = kp_q; mul_op = OP_W'(e_q);         end
            I: begin gain = ki_q; mul_op = OP_W'(integ_new_q); end
            D: begin gain = kd_q; mul_op = OP_W'(d_q);         end
            default: ;
        endcase
        product = PROD_W'($signed({1'b0, gain})) * PROD_W'(mul_op);
        acc_sum = acc + ACC_W'(product);
    end

    // ---------------- output clamp and anti-windup ----------------
    logic signed [ACC_W-1:0]    y;
    logic        [OUT_BITS-1:0] stim_next;
    logic                       out_hi, out_lo;
    logic                       windup;

    assign y = acc_sum >>> KSHIFT;

    pid_sat #(
        .IN_W       (ACC_W),
        .OUT_W      (OUT_BITS),
        .OUT_SIGNED (1'b0)
    ) u_out_sat (
        .din    (y),
        .dout   (stim_next),
        .sat_hi (out_hi),
        .sat_lo (out_lo)
    );

    // Freeze the integrator only when the error pushes further into the clipped side.
    assign windup = (out_hi && !e_q[E_W-1] && (e_q != '0)) || (out_lo && e_q[E_W-1]);

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch_q        <= '0;
            clr_q       <= 1'b0;
            sp_q        <= '0;
            pv_q        <= '0;
            kp_q        <= '0;
            ki_q        <= '0;
            kd_q        <= '0;
            e_q         <= '0;
            d_q         <= '0;
            integ_new_q <= '0;
            integ_old_q <= '0;
            acc         <= '0;
        end else begin
            if (accept) begin
                ch_q  <= pv_ch;
                clr_q <= int_clr;
                sp_q  <= sp;
                pv_q  <= pv;
                kp_q  <= kp;
                ki_q  <= ki;
                kd_q  <= kd;
            end
            if (state == ERR) begin
                e_q         <= e_cur;
                d_q         <= d_cur;
                integ_new_q <= integ_clamped;
                integ_old_q <= integ_prior;
            end
            if (state == P) begin
                acc <= ACC_W'(product);
            end else if (state == I || state == D) begin
                acc <= acc_sum;
            end
        end
    end

    // Results commit on the edge into OUT so stimulus is already valid while out_stb is high.
    // NOTE: the per-channel arrays carry an async reset because a cleared loop history is part of reset state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                integ[c]    <= '0;
                prev_err[c] <= '0;
            end
            stimulus <= '0;
            out_ch   <= '0;
        end else if (state == D) begin
            stimulus       <= stim_next;
            out_ch         <= ch_q;
            prev_err[ch_q] <= e_q;
            integ[ch_q]    <= windup ? integ_old_q : integ_new_q;
        end
    end

endmodule

// File: tb/tb_pid_mux.sv
// Scoreboard bench for pid_mux: expected outputs are queued on each strobe and popped on out_stb.
module tb_pid_mux;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pv_stb;
    logic [1:0] pv_ch;
    logic       int_clr;
    logic [7:0] sp, pv, kp, ki, kd;
    logic       busy, out_stb;
    logic [1:0] out_ch;
    logic [7:0] stimulus;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] stim;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   errors    = 0;
    int   stb_count = 0;

    always #5 clk = ~clk;

    pid_mux #(
        .BITS     (8),
        .CHANNELS (4),
        .ACC_BITS (16),
        .OUT_BITS (8),
        .KSHIFT   (2)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .pv_stb   (pv_stb),
        .pv_ch    (pv_ch),
        .int_clr  (int_clr),
        .sp       (sp),
        .pv       (pv),
        .kp       (kp),
        .ki       (ki),
        .kd       (kd),
        .busy     (busy),
        .out_stb  (out_stb),
        .out_ch   (out_ch),
        .stimulus (stimulus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset_n === 1'b1 && out_stb === 1'b1) begin
            stb_count++;
            if (sb.size() == 0) begin
                check("unexpected_out_stb", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("stimulus", 32'(stimulus), 32'(e.stim));
                check("out_ch", 32'(out_ch), 32'(e.ch));
            end
        end
    end

    // One sample; strobes injected at cycles inj_a/inj_b land while busy and must be ignored.
    task automatic run_sample(input logic [1:0] ch, input logic clr,
                              input logic [7:0] s, input logic [7:0] p,
                              input logic [7:0] gp, input logic [7:0] gi, input logic [7:0] gd,
                              input logic [7:0] exp_stim, input int inj_a, input int inj_b);
        exp_t e;
        @(negedge clk);
        pv_ch = ch; int_clr = clr; sp = s; pv = p; kp = gp; ki = gi; kd = gd;
        pv_stb = 1'b1;
        e.ch = ch;
        e.stim = exp_stim;
        sb.push_back(e);
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            pv_stb = 1'b0;
            check($sformatf("busy_c%0d", cyc), 32'(busy), 32'(cyc <= 5));
            check($sformatf("out_stb_c%0d", cyc), 32'(out_stb), 32'(cyc == 5));
            if (cyc == inj_a || cyc == inj_b) begin
                pv_ch   = (cyc == inj_a) ? 2'd1 : 2'd3;
                int_clr = 1'b1;
                sp = 8'd200; pv = 8'd0; kp = 8'd255; ki = 8'd255; kd = 8'd255;
                pv_stb  = 1'b1;
            end
        end
    endtask

    initial begin
        int stb_before;
        reset_n = 1'b0;
        pv_stb = 1'b0; pv_ch = '0; int_clr = 1'b0;
        sp = '0; pv = '0; kp = '0; ki = '0; kd = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_stb", 32'(out_stb), 32'd0);
        check("rst_stimulus", 32'(stimulus), 32'd0);
        check("rst_out_ch", 32'(out_ch), 32'd0);
        reset_n = 1'b1;

        // Proportional: e=20, kp=4 -> 80 >>> 2
        run_sample(2'd0, 1'b0, 8'd100, 8'd80, 8'd4, 8'd0, 8'd0, 8'd20, 0, 0);

        // Integral: e=4 accumulates 4, 8, 12; clear restarts at 4
        run_sample(2'd1, 1'b0, 8'd10, 8'd6, 8'd0, 8'd1, 8'd0, 8'd1, 0, 0);
        run_sample(2'd1, 1'b0, 8'd10, 8'd6, 8'd0, 8'd1, 8'd0, 8'd2, 0, 0);
        run_sample(2'd1, 1'b0, 8'd10, 8'd6, 8'd0, 8'd1, 8'd0, 8'd3, 0, 0);
        run_sample(2'd1, 1'b1, 8'd10, 8'd6, 8'd0, 8'd1, 8'd0, 8'd1, 0, 0);

        // Derivative: d=10 then 0
        run_sample(2'd2, 1'b0, 8'd20, 8'd10, 8'd0, 8'd0, 8'd4, 8'd10, 0, 0);
        run_sample(2'd2, 1'b0, 8'd20, 8'd10, 8'd0, 8'd0, 8'd4, 8'd0, 0, 0);

        // Saturation high twice with integrator frozen, then zero error, then saturation low
        run_sample(2'd3, 1'b0, 8'd255, 8'd0, 8'd15, 8'd1, 8'd0, 8'd255, 0, 0);
        run_sample(2'd3, 1'b0, 8'd255, 8'd0, 8'd15, 8'd1, 8'd0, 8'd255, 0, 0);
        run_sample(2'd3, 1'b0, 8'd50, 8'd50, 8'd0, 8'd1, 8'd0, 8'd0, 0, 0);
        run_sample(2'd3, 1'b0, 8'd0, 8'd255, 8'd15, 8'd0, 8'd0, 8'd0, 0, 0);

        // Strobes while busy (ch1 at cycle 2, ch3 at cycle 5) are dropped; with 4 channels every
        // 2-bit index is in range, so the out-of-range case has no encoding here.
        stb_before = stb_count;
        run_sample(2'd0, 1'b0, 8'd100, 8'd80, 8'd4, 8'd0, 8'd0, 8'd20, 2, 5);
        check("iso_one_stb", 32'(stb_count - stb_before), 32'd1);
        // ch1 integrator was 4; untouched -> 8 -> 2
        run_sample(2'd1, 1'b0, 8'd10, 8'd6, 8'd0, 8'd1, 8'd0, 8'd2, 0, 0);

        // Reset at cycle 3 of an in-flight ch1 sample
        @(negedge clk);
        pv_ch = 2'd1; int_clr = 1'b0; sp = 8'd10; pv = 8'd6; kp = 8'd0; ki = 8'd1; kd = 8'd0;
        pv_stb = 1'b1;
        @(negedge clk);
        pv_stb = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_out_stb", 32'(out_stb), 32'd0);
        check("midrst_stimulus", 32'(stimulus), 32'd0);
        check("midrst_out_ch", 32'(out_ch), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        stb_before = stb_count;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("midrst_quiet_%0d", i), 32'(out_stb), 32'd0);
        end
        check("midrst_no_stb", 32'(stb_count - stb_before), 32'd0);
        run_sample(2'd1, 1'b0, 8'd10, 8'd6, 8'd0, 8'd1, 8'd0, 8'd1, 0, 0);

        repeat (2) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pid_mux.md
Name: pid_mux

Overview:
- Time-multiplexed, parametrised PID controller serving CHANNELS independent loops from one shared multiplier.
- Successor to the single-channel 4-bit PID. Adds per-channel integrator/derivative memory, configurable widths, a fixed-point gain shift, output saturation, integrator anti-windup and a busy/done handshake.
- Sits between the sampled process-value front end and the actuator drive logic.

Parameters:
- BITS, 8: width of sp, pv, kp, ki, kd (all unsigned).
- CHANNELS, 4: number of independent loops (>=1).
- ACC_BITS, 16: signed integrator width per channel.
- OUT_BITS, 8: unsigned stimulus width.
- KSHIFT, 2: arithmetic right shift applied to the gain sum (fractional gain bits).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- pv_stb  in  1  sample strobe; all inputs below are valid on this cycle.
- pv_ch  in  max(1,$clog2(CHANNELS))  channel index of the sample.
- int_clr  in  1  with pv_stb: zero this channel's integrator and prev_err before computing.
- sp  in  BITS  setpoint.
- pv  in  BITS  process value.
- kp, ki, kd  in  BITS each  gains.
- busy  out  1  computation in progress.
- out_stb  out  1  one-cycle pulse when stimulus/out_ch are updated.
- out_ch  out  width of pv_ch  channel of the current stimulus.
- stimulus  out  OUT_BITS  saturated controller output.

Behaviour:
- Reset (async, any state): FSM to IDLE; all integ[], prev_err[], stimulus, out_ch, out_stb and busy go to 0; any in-flight computation is aborted and produces no out_stb.
- Accept: in IDLE, pv_stb with pv_ch < CHANNELS latches all inputs (cycle 0). busy=1 from cycle 1 until out_stb (inclusive); busy=0 in the cycle after out_stb.
- Ignored strobes: pv_stb while busy, or with pv_ch >= CHANNELS, has no effect on any state and produces no output.
- FSM: IDLE -> ERR -> P -> I -> D -> OUT -> IDLE, one cycle each. out_stb is high in OUT, i.e. cycle 5 after pv_stb. Next accept is possible at cycle 6.
- ERR:
  - e = sp - pv, signed BITS+1.
  - If int_clr was latched, integ and prev_err are treated as 0 for this sample.
  - integ_new = integ[ch] + e, saturated to the signed ACC_BITS range.
  - d = e - prev_err[ch], signed BITS+2.
- P: acc = kp*e.
- I: acc += ki*integ_new.
- D: acc += kd*d.
- Single shared signed multiplier: gain zero-extended, operand signed. acc is signed ACC_BITS+BITS+3 bits; no overflow is possible.
- OUT:
  - y = acc >>> KSHIFT (arithmetic shift).
  - stimulus = 0 if y < 0; 2^OUT_BITS-1 if y exceeds it; otherwise y.
  - out_ch = channel; out_stb = 1.
  - prev_err[ch] <= e.
- Anti-windup: integ[ch] <= integ_new, except when the output saturated high with e > 0, or saturated low with e < 0. In those cases integ[ch] keeps its prior value (0 if int_clr was latched).
- Other channels' state is never touched.
- stimulus and out_ch hold their values between updates.

Decomposition:
- Package pid_pkg: the FSM state enum (IDLE, ERR, P, I, D, OUT) and localparam width functions (error, derivative, accumulator widths) and the saturation helper functions.
- One sub-module, pid_sat: a parametrised signed-to-range saturator. It is used for the integrator clamp (signed ACC_BITS) and the output clamp (unsigned OUT_BITS), and also reports a hi/lo saturation flag for anti-windup.
- Per-channel state is held in register arrays indexed by channel.

Test Plan (BITS=8, CHANNELS=4, ACC_BITS=16, OUT_BITS=8, KSHIFT=2):
- Proportional: ch0, sp=100, pv=80, kp=4, ki=kd=0 -> out_stb exactly 5 cycles after pv_stb, stimulus=20, out_ch=0; busy high for cycles 1-5.
- Integral: ch1, kp=kd=0, ki=1, sp=10, pv=6, three samples -> stimulus 1, 2, 3. Then a fourth sample with int_clr=1 -> stimulus 1.
- Derivative: ch2, kd=4 only, sp=20, pv=10, two samples -> stimulus 10, then 0.
- Saturation/anti-windup: ch3, kp=15, ki=1, sp=255, pv=0, two samples -> stimulus 255 both times. Then kp=0, ki=1, sp=pv=50 -> stimulus 0 (a wound-up integrator would give 127). Separately, sp=0, pv=255, kp=15 -> stimulus 0.
- Busy/isolation: pv_stb ch0 followed by pv_stb ch1 at cycle 2, and a pv_stb with pv_ch=4 on CHANNELS=4 -> exactly one out_stb (ch0). A later ch1 integral sample shows ch1's integrator unchanged.
- Reset mid-op: reset_n low at cycle 3 after pv_stb -> no out_stb, busy=0, stimulus=0. A repeat of the integral test starts again from stimulus 1.
